sky130_gpio_mode_seq: RTL

//  Run-time mode sequencer for one Sky130 Openframe GPIO pad. It accepts mode-change

---
 rtl/sky130_gpio_mode_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sky130_gpio_mode_seq.sv
// Glitch-safe run-time mode sequencer for one Sky130 Openframe GPIO pad.
// Optional `GPIO_SEQ_LOCK_EN adds a sticky lock input that rejects all requests until reset.
module sky130_gpio_mode_seq #(
  parameter logic [2:0] RESET_MODE    = 3'd1,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef GPIO_SEQ_LOCK_EN
  input  logic       lock,
`endif
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_mode,
  input  logic [1:0] req_analog,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] cur_mode,
  input  logic       io_out,
  input  logic       io_oeb,
  output logic       io_in,
  input  logic       gpio_in,
  output logic [2:0] gpio_dm,
  output logic       gpio_inp_dis,
  output logic       gpio_oeb_out,
  output logic       gpio_out_val,
  output logic       gpio_analog_en,
  output logic       gpio_analog_sel,
  output logic       gpio_analog_pol
);

  typedef enum logic [1:0] {IDLE, RELEASE, SETTLE, ENABLE} state_t;

  typedef struct packed {
    logic [2:0] dm;
    logic       inp_dis;
    logic       oeb;
    logic       out;
    logic       an_en;
    logic       an_sel;
    logic       an_pol;
    logic       out_pt;  // out_val follows io_out
    logic       oeb_pt;  // oeb_out follows io_oeb
  } pad_cfg_t;

  function automatic pad_cfg_t decode(input logic [2:0] m, input logic [1:0] an);
    pad_cfg_t c;
    c = '0;
    case (m)
      3'd0: begin c.inp_dis = 1'b1; c.oeb = 1'b1; c.an_en = 1'b1; {c.an_sel, c.an_pol} = an; end
      3'd1: begin c.dm = 3'b001; c.oeb = 1'b1; end
      3'd2: c.dm = 3'b011;
      3'd3: begin c.dm = 3'b010; c.out = 1'b1; end
      3'd4: begin c.dm = 3'b110; c.inp_dis = 1'b1; c.out_pt = 1'b1; end
      3'd5: begin c.dm = 3'b110; c.out_pt = 1'b1; c.oeb_pt = 1'b1; end
      default: c.oeb = 1'b1;
    endcase
    return c;
  endfunction

  state_t           state_q, state_d;
  pad_cfg_t         cfg_q, cfg_d, new_cfg;
  logic [2:0]       cur_q, cur_d, new_mode_q, new_mode_d;
  logic [1:0]       new_an_q, new_an_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
  logic             locked;

`ifdef GPIO_SEQ_LOCK_EN
  logic lock_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else if (lock) lock_q <= 1'b1;
  end
  assign locked = lock_q | lock;
`else
  assign locked = 1'b0;
`endif

  assign new_cfg = decode(new_mode_q, new_an_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cfg_q      <= decode(RESET_MODE, 2'b00);
      cur_q      <= RESET_MODE;
      new_mode_q <= RESET_MODE;
      new_an_q   <= 2'b00;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      cur_q      <= cur_d;
      new_mode_q <= new_mode_d;
      new_an_q   <= new_an_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    cur_d      = cur_q;
    new_mode_d = new_mode_q;
    new_an_d   = new_an_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        if (req_mode > 3'd5 || locked) err_d = 1'b1;
        else if (req_mode == cur_q && req_mode != 3'd0) done_d = 1'b1;
        else begin
          // Drop drive first, keeping the old dm until the pad is tristated.
          new_mode_d    = req_mode;
          new_an_d      = req_analog;
          cfg_d.oeb     = 1'b1;
          cfg_d.out     = 1'b0;
          cfg_d.an_en   = 1'b0;
          cfg_d.out_pt  = 1'b0;
          cfg_d.oeb_pt  = 1'b0;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        cfg_d.dm      = new_cfg.dm;
        cfg_d.inp_dis = new_cfg.inp_dis;
        cfg_d.an_sel  = new_cfg.an_sel;
        cfg_d.an_pol  = new_cfg.an_pol;
        cnt_d         = CNT_W'(SETTLE_CYCLES - 1);
        state_d       = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          cfg_d   = new_cfg;
          cur_d   = new_mode_q;
          done_d  = 1'b1;
          state_d = ENABLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ENABLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready       = (state_q == IDLE);
  assign busy            = ~req_ready;
  assign done            = done_q;
  assign err             = err_q;
  assign cur_mode        = cur_q;
  assign io_in           = gpio_in;
  assign gpio_dm         = cfg_q.dm;
  assign gpio_inp_dis    = cfg_q.inp_dis;
  assign gpio_oeb_out    = cfg_q.oeb_pt ? io_oeb : cfg_q.oeb;
  assign gpio_out_val    = cfg_q.out_pt ? io_out : cfg_q.out;
  assign gpio_analog_en  = cfg_q.an_en;
  assign gpio_analog_sel = cfg_q.an_sel;
  assign gpio_analog_pol = cfg_q.an_pol;

endmodule
